vgm_axi_wr_slave: RTL and testbench

- AXI4 write-channel slave: accepts AW, W and B channel traffic into an internal word memory.
- It is the RTL endpoint that the team's AXI master agent drives and monitors.
- Consumes write bursts issued by the agent's driver and produces the B responses the monitor checks.
- Single outstanding transaction. A debug read port exposes memory contents to the bench.

---
 rtl/vgm_axi_wr_slave.sv | 162 ++++++++++++++++
 tb/tb_vgm_axi_wr_slave.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vgm_axi_wr_slave.sv
// AXI4 write-channel slave backed by an internal word memory.
// One write transaction is in flight at a time: IDLE (AW) -> DATA (W beats) -> RESP (B).
// A debug port returns memory contents with one cycle of latency.
//
// Ports:
//   ACLK, ARESETn            clock (rising edge), asynchronous active-low reset
//   AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID/AWREADY   write address channel
//   WDATA/WSTRB/WLAST/WVALID/WREADY                    write data channel
//   BID/BRESP/BVALID/BREADY                            write response channel
//   dbg_addr, dbg_data       debug word index in, registered memory word out
module vgm_axi_wr_slave #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned MEM_DEPTH  = 256
) (
  input  logic                         ACLK,
  input  logic                         ARESETn,
  input  logic [ID_WIDTH-1:0]          AWID,
  input  logic [ADDR_WIDTH-1:0]        AWADDR,
  input  logic [7:0]                   AWLEN,
  input  logic [2:0]                   AWSIZE,
  input  logic [1:0]                   AWBURST,
  input  logic                         AWVALID,
  output logic                         AWREADY,
  input  logic [DATA_WIDTH-1:0]        WDATA,
  input  logic [DATA_WIDTH/8-1:0]      WSTRB,
  input  logic                         WLAST,
  input  logic                         WVALID,
  output logic                         WREADY,
  output logic [ID_WIDTH-1:0]          BID,
  output logic [1:0]                   BRESP,
  output logic                         BVALID,
  input  logic                         BREADY,
  input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0]        dbg_data
);

  localparam int unsigned StrbW   = DATA_WIDTH / 8;
  localparam int unsigned OffW    = $clog2(StrbW);
  localparam int unsigned IdxW    = $clog2(MEM_DEPTH);
  localparam logic [2:0]  SizeNat = 3'(OffW);

  typedef enum logic [1:0] {StIdle, StData, StResp} state_e;

  state_e                  state_q, state_d;
  logic                    awready_q, wready_q, bvalid_q;
  logic [ID_WIDTH-1:0]     id_q;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]              len_q;
  logic [7:0]              beat_q, beat_d;
  logic [1:0]              burst_q;
  // cfg_err: AW-time error, gates all writes. err: sticky response error.
  logic                    cfg_err_q, cfg_err_d;
  logic                    err_q, err_d;

  logic                    aw_hs, w_hs, b_hs;
  logic [ADDR_WIDTH-1:0]   word;
  logic                    in_range;
  logic                    last_beat;
  logic                    mem_we;

  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

  assign aw_hs     = AWVALID && awready_q;
  assign w_hs      = WVALID && wready_q;
  assign b_hs      = bvalid_q && BREADY;
  assign word      = addr_q >> OffW;
  // MEM_DEPTH is a power of two, so in range means no bits above the index.
  assign in_range  = ((word >> IdxW) == '0);
  assign last_beat = (beat_q == len_q);
  assign mem_we    = w_hs && !cfg_err_q && in_range;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    beat_d    = beat_q;
    err_d     = err_q;
    cfg_err_d = cfg_err_q;
    case (state_q)
      StIdle: begin
        if (aw_hs) begin
          state_d   = StData;
          addr_d    = AWADDR;
          beat_d    = '0;
          cfg_err_d = (AWSIZE != SizeNat) || AWBURST[1];
          err_d     = cfg_err_d;
        end
      end
      StData: begin
        if (w_hs) begin
          // The beat count alone ends the burst; a misplaced WLAST only flags an error.
          if (!in_range || (WLAST != last_beat)) err_d = 1'b1;
          if (burst_q == 2'b01) addr_d = addr_q + ADDR_WIDTH'(StrbW);
          beat_d = beat_q + 8'd1;
          if (last_beat) state_d = StResp;
        end
      end
      StResp: begin
        if (b_hs) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs are registered from the next state, so each ready/valid
  // changes on the edge that moves the FSM.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= StIdle;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      burst_q   <= '0;
      cfg_err_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      awready_q <= (state_d == StIdle);
      wready_q  <= (state_d == StData);
      bvalid_q  <= (state_d == StResp);
      addr_q    <= addr_d;
      beat_q    <= beat_d;
      cfg_err_q <= cfg_err_d;
      err_q     <= err_d;
      if (aw_hs) begin
        id_q    <= AWID;
        len_q   <= AWLEN;
        burst_q <= AWBURST;
      end
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge ACLK) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < StrbW; b++) begin
        if (WSTRB[b]) mem[word[IdxW-1:0]][8*b +: 8] <= WDATA[8*b +: 8];
      end
    end
  end

  // Read-before-write: a same-cycle write to dbg_addr shows up one cycle later.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      dbg_data <= '0;
    end else begin
      dbg_data <= mem[dbg_addr];
    end
  end

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BID     = id_q;
  assign BRESP   = {err_q && bvalid_q, 1'b0};

endmodule

// File: tb/tb_vgm_axi_wr_slave.sv
module tb_vgm_axi_wr_slave;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [3:0]  AWID;
  logic [15:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic [3:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [7:0]  dbg_addr;
  logic [31:0] dbg_data;

  vgm_axi_wr_slave dut (
    .ACLK     (ACLK),
    .ARESETn  (ARESETn),
    .AWID     (AWID),
    .AWADDR   (AWADDR),
    .AWLEN    (AWLEN),
    .AWSIZE   (AWSIZE),
    .AWBURST  (AWBURST),
    .AWVALID  (AWVALID),
    .AWREADY  (AWREADY),
    .WDATA    (WDATA),
    .WSTRB    (WSTRB),
    .WLAST    (WLAST),
    .WVALID   (WVALID),
    .WREADY   (WREADY),
    .BID      (BID),
    .BRESP    (BRESP),
    .BVALID   (BVALID),
    .BREADY   (BREADY),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always #5 ACLK = ~ACLK;

  // Reference memory and per-beat stimulus of the current burst.
  logic [31:0] model     [256];
  logic [31:0] beat_data [256];
  logic [3:0]  beat_strb [256];
  logic        beat_last [256];
  bit          mem_known = 1'b0;
  int          n_pass    = 0;
  int          n_checks  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic fill_beats(input int len, input bit rand_strb);
    for (int i = 0; i < 256; i++) begin
      beat_data[i] = $urandom;
      beat_strb[i] = rand_strb ? 4'($urandom) : 4'hF;
      beat_last[i] = (i == len);
    end
  endtask

  // Applies a burst to the reference memory from the protocol rules; returns the error flag.
  function automatic bit model_burst(input logic [15:0] addr, input int len,
                                     input logic [2:0] size, input logic [1:0] burst);
    int unsigned a;
    int unsigned w;
    bit cfg;
    bit err;
    a   = 32'(addr);
    cfg = (size != 3'd2) || (burst == 2'b10) || (burst == 2'b11);
    err = cfg;
    for (int i = 0; i <= len; i++) begin
      w = a / 4;
      if (w >= 256) err = 1'b1;
      else if (!cfg) begin
        for (int b = 0; b < 4; b++)
          if (beat_strb[i][b]) model[w][8*b +: 8] = beat_data[i][8*b +: 8];
      end
      if ((i == len) != beat_last[i]) err = 1'b1;
      if (burst == 2'b01) a = (a + 4) % 65536;
    end
    return err;
  endfunction

  task automatic check_mem(input string tag);
    for (int w = 0; w < 256; w++) begin
      dbg_addr = 8'(w);
      @(posedge ACLK); #1;
      check($sformatf("%s/mem[%0d]", tag, w), 64'(dbg_data), 64'(model[w]));
    end
  endtask

  task automatic wait_awready(input string tag);
    int t;
    t = 0;
    while (AWREADY !== 1'b1 && t < 20) begin
      @(posedge ACLK); #1;
      t++;
    end
    check({tag, "/awready_idle"}, 64'(AWREADY), 64'(1'b1));
  endtask

  task automatic run_burst(input string tag, input logic [3:0] id, input logic [15:0] addr,
                           input int len, input logic [2:0] size, input logic [1:0] burst,
                           input int bdelay, input bit noise);
    bit          exp_err;
    logic [7:0]  w0;
    logic [31:0] old_w0;
    w0      = addr[9:2];
    old_w0  = model[w0];
    exp_err = model_burst(addr, len, size, burst);
    dbg_addr = w0;
    wait_awready(tag);
    check({tag, "/wready_idle"}, 64'(WREADY), 64'(1'b0));
    // W traffic before the AW handshake must be ignored.
    if (noise) begin
      WVALID = 1'b1; WDATA = $urandom; WSTRB = 4'hF;
    end
    AWID = id; AWADDR = addr; AWLEN = 8'(len); AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
    @(posedge ACLK); #1;
    WVALID = 1'b0;
    // A stray address during DATA must be ignored.
    AWVALID = noise;
    AWADDR  = 16'($urandom); AWLEN = 8'($urandom); AWID = 4'($urandom);
    check({tag, "/awready_drop"}, 64'(AWREADY), 64'(1'b0));
    check({tag, "/wready_up"}, 64'(WREADY), 64'(1'b1));
    for (int i = 0; i <= len; i++) begin
      if (noise && ($urandom_range(0, 1) == 1)) begin
        @(posedge ACLK); #1;
        check({tag, "/wready_gap"}, 64'(WREADY), 64'(1'b1));
        check({tag, "/bvalid_gap"}, 64'(BVALID), 64'(1'b0));
      end
      WDATA = beat_data[i]; WSTRB = beat_strb[i]; WLAST = beat_last[i]; WVALID = 1'b1;
      @(posedge ACLK); #1;
      WVALID = 1'b0; WLAST = 1'b0;
      if (i == 0 && mem_known) check({tag, "/dbg_old"}, 64'(dbg_data), 64'(old_w0));
      if (i < len) check({tag, "/wready_hold"}, 64'(WREADY), 64'(1'b1));
      check({tag, "/bvalid_timing"}, 64'(BVALID), 64'(i == len));
    end
    check({tag, "/wready_drop"}, 64'(WREADY), 64'(1'b0));
    check({tag, "/bid"}, 64'(BID), 64'(id));
    check({tag, "/bresp"}, 64'(BRESP), 64'({exp_err, 1'b0}));
    check({tag, "/awready_resp"}, 64'(AWREADY), 64'(1'b0));
    AWVALID = 1'b0;
    WVALID  = noise;
    for (int c = 0; c <= bdelay; c++) begin
      BREADY = (c == bdelay);
      @(posedge ACLK); #1;
      if (c == 0) check({tag, "/dbg_new"}, 64'(dbg_data), 64'(model[w0]));
      if (c < bdelay) begin
        check({tag, "/b_stall_valid"}, 64'(BVALID), 64'(1'b1));
        check({tag, "/b_stall_id"}, 64'(BID), 64'(id));
        check({tag, "/b_stall_resp"}, 64'(BRESP), 64'({exp_err, 1'b0}));
        check({tag, "/b_stall_awready"}, 64'(AWREADY), 64'(1'b0));
      end
    end
    BREADY = 1'b0;
    WVALID = 1'b0;
    check({tag, "/bvalid_clear"}, 64'(BVALID), 64'(1'b0));
    check({tag, "/awready_back"}, 64'(AWREADY), 64'(1'b1));
    check_mem(tag);
  endtask

  initial begin
    logic [15:0] ra;
    logic [2:0]  rs;
    logic [1:0]  rb;
    int          rl;
    int          pick;

    ARESETn = 1'b0; AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0;
    AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    dbg_addr = '0;
    repeat (2) @(posedge ACLK);
    #1;
    check("rst/awready", 64'(AWREADY), 64'(1'b0));
    check("rst/wready", 64'(WREADY), 64'(1'b0));
    check("rst/bvalid", 64'(BVALID), 64'(1'b0));
    check("rst/bresp", 64'(BRESP), 64'(2'b00));
    check("rst/bid", 64'(BID), 64'(4'h0));
    check("rst/dbg_data", 64'(dbg_data), 64'(32'h0));
    ARESETn = 1'b1;
    #1;
    check("rst/awready_before_edge", 64'(AWREADY), 64'(1'b0));
    @(posedge ACLK); #1;
    check("rst/awready_first_edge", 64'(AWREADY), 64'(1'b1));

    // Fill the whole memory so the reference model is fully known.
    for (int w = 0; w < 256; w++) model[w] = '0;
    fill_beats(255, 1'b0);
    run_burst("init", 4'h1, 16'h0000, 255, 3'd2, 2'b01, 0, 1'b0);
    mem_known = 1'b1;

    fill_beats(0, 1'b0);
    beat_data[0] = 32'hDEADBEEF;
    run_burst("single", 4'h5, 16'h0010, 0, 3'd2, 2'b01, 0, 1'b0);

    fill_beats(3, 1'b0);
    for (int i = 0; i < 4; i++) beat_data[i] = 32'(i + 1);
    beat_strb[1] = 4'h3;
    run_burst("incr4", 4'h9, 16'h0020, 3, 3'd2, 2'b01, 1, 1'b0);

    fill_beats(1, 1'b0);
    run_burst("oor", 4'h2, 16'h03FC, 1, 3'd2, 2'b01, 0, 1'b0);

    fill_beats(3, 1'b0);
    beat_last[1] = 1'b1;
    run_burst("early_wlast", 4'h3, 16'h0040, 3, 3'd2, 2'b01, 0, 1'b0);

    fill_beats(1, 1'b0);
    run_burst("bad_size", 4'h4, 16'h0050, 1, 3'd1, 2'b01, 0, 1'b0);

    fill_beats(1, 1'b0);
    run_burst("wrap_burst", 4'h6, 16'h0060, 1, 3'd2, 2'b10, 0, 1'b0);

    fill_beats(2, 1'b1);
    run_burst("backpressure", 4'hC, 16'h0080, 2, 3'd2, 2'b01, 5, 1'b0);

    fill_beats(2, 1'b0);
    run_burst("addr_wrap", 4'h7, 16'hFFF8, 2, 3'd2, 2'b01, 0, 1'b0);

    fill_beats(3, 1'b1);
    run_burst("fixed", 4'h8, 16'h0090, 3, 3'd2, 2'b00, 2, 1'b1);

    // Reset after beat 2 of a 4-beat burst: beats 1-2 stay, no response follows.
    fill_beats(3, 1'b0);
    void'(model_burst(16'h0100, 1, 3'd2, 2'b01));
    wait_awready("midrst");
    AWID = 4'hA; AWADDR = 16'h0100; AWLEN = 8'd3; AWSIZE = 3'd2; AWBURST = 2'b01;
    AWVALID = 1'b1;
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
    for (int i = 0; i < 2; i++) begin
      WDATA = beat_data[i]; WSTRB = beat_strb[i]; WLAST = 1'b0; WVALID = 1'b1;
      @(posedge ACLK); #1;
    end
    WVALID  = 1'b0;
    ARESETn = 1'b0;
    #1;
    check("midrst/awready", 64'(AWREADY), 64'(1'b0));
    check("midrst/wready", 64'(WREADY), 64'(1'b0));
    check("midrst/bvalid", 64'(BVALID), 64'(1'b0));
    check("midrst/bresp", 64'(BRESP), 64'(2'b00));
    check("midrst/bid", 64'(BID), 64'(4'h0));
    check("midrst/dbg_data", 64'(dbg_data), 64'(32'h0));
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    #1;
    check("midrst/awready_before_edge", 64'(AWREADY), 64'(1'b0));
    @(posedge ACLK); #1;
    check("midrst/awready_first_edge", 64'(AWREADY), 64'(1'b1));
    for (int c = 0; c < 4; c++) begin
      @(posedge ACLK); #1;
      check("midrst/no_bvalid", 64'(BVALID), 64'(1'b0));
    end
    check_mem("midrst");

    for (int n = 0; n < 12; n++) begin
      pick = int'($urandom_range(0, 9));
      ra   = (pick == 0) ? 16'($urandom) : 16'($urandom_range(0, 1100));
      rs   = ($urandom_range(0, 9) == 0) ? 3'd1 : 3'd2;
      pick = int'($urandom_range(0, 9));
      rb   = (pick == 0) ? 2'b10 : (pick == 1) ? 2'b11 : (pick < 5) ? 2'b00 : 2'b01;
      rl   = int'($urandom_range(0, 7));
      fill_beats(rl, 1'b1);
      if ($urandom_range(0, 5) == 0) begin
        pick = int'($urandom_range(0, rl));
        beat_last[pick] = ~beat_last[pick];
      end
      run_burst($sformatf("rand%0d", n), 4'($urandom), ra, rl, rs, rb,
                int'($urandom_range(0, 3)), 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
